// File: rtl/mem_bus_master.sv
// CPU-side burst master: one ADDR cycle followed by BURST_LEN data cycles on a shared AddrData bus.
// Optional page check on accepted requests is enabled by defining MBM_PAGE_CHECK_EN.
`timescale 1ns/1ps

module mem_bus_master #(
    parameter int                   BUSWIDTH   = 16,
    parameter int                   BURST_LEN  = 4,
    parameter int                   PAGE_BITS  = 4,
    parameter logic [PAGE_BITS-1:0] VALID_PAGE = 'h2
) (
    input  logic                          clk,
    input  logic                          resetL,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rw,
    input  logic [BUSWIDTH-1:0]           req_addr,
    input  logic [BURST_LEN*BUSWIDTH-1:0] req_wdata,
    output logic [BURST_LEN*BUSWIDTH-1:0] rd_data,
    output logic                          done,
    output logic                          err,
    output logic [BUSWIDTH-1:0]           AddrData_o,
    output logic                          AddrData_oe,
    input  logic [BUSWIDTH-1:0]           AddrData_i,
    output logic                          AddrValid,
    output logic                          rw
);

    // state   | meaning
    // IDLE    | waiting for a request, bus released
    // ADDR    | base address and direction on the bus
    // DATA    | data beats; beat_cnt counts down to the last one

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      word_idx;
    logic                  rw_q;
    logic [BUSWIDTH-1:0]   addr_q;
    logic [BUSWIDTH-1:0]   wdata_q [BURST_LEN];
    logic [BUSWIDTH-1:0]   rd_q    [BURST_LEN];
    logic [BUSWIDTH-1:0]   last_q;
    logic                  done_q;
    logic                  accept;
    logic                  page_ok;
    logic                  last_beat;
    logic                  drive_oe;
    logic [BUSWIDTH-1:0]   drive_val;

`ifdef MBM_PAGE_CHECK_EN
    logic                  err_q;
    assign page_ok = (req_addr[BUSWIDTH-1 -: PAGE_BITS] == VALID_PAGE);
`else
    assign page_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        last_beat = (state == ST_DATA) && (beat_cnt == '0);
        req_ready = (state == ST_IDLE) || last_beat;
        accept    = req_valid && req_ready;
        word_idx  = LAST_IDX - beat_cnt;
        state_nxt = state;
        AddrValid = 1'b0;
        rw        = 1'b0;
        drive_oe  = 1'b0;
        drive_val = last_q;
        case (state)
            ST_IDLE: begin
                if (accept && page_ok) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_nxt = ST_DATA;
                AddrValid = 1'b1;
                rw        = rw_q;
                drive_oe  = 1'b1;
                drive_val = addr_q;
            end
            ST_DATA: begin
                // reads turn the bus around right after ADDR and keep it released
                drive_oe = !rw_q;
                if (!rw_q) begin
                    drive_val = wdata_q[word_idx];
                end
                if (last_beat) begin
                    state_nxt = (accept && page_ok) ? ST_ADDR : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            beat_cnt <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            last_q   <= '0;
            done_q   <= 1'b0;
            for (int k = 0; k < BURST_LEN; k++) begin
                wdata_q[k] <= '0;
                rd_q[k]    <= '0;
            end
        end else begin
            last_q <= drive_val;
            done_q <= last_beat;
            if (accept) begin
                rw_q   <= req_rw;
                addr_q <= req_addr;
                for (int k = 0; k < BURST_LEN; k++) begin
                    wdata_q[k] <= req_wdata[k*BUSWIDTH +: BUSWIDTH];
                end
            end
            if (state == ST_ADDR) begin
                beat_cnt <= LAST_IDX;
            end else if ((state == ST_DATA) && !last_beat) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            if ((state == ST_DATA) && rw_q) begin
                rd_q[word_idx] <= AddrData_i;
            end
        end
    end

`ifdef MBM_PAGE_CHECK_EN
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !page_ok;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < BURST_LEN; g++) begin : g_rd_pack
            assign rd_data[g*BUSWIDTH +: BUSWIDTH] = rd_q[g];
        end
    endgenerate

    assign done        = done_q;
    assign AddrData_o  = drive_val;
    assign AddrData_oe = drive_oe;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: a request queue plus a paged memory model checked at every falling edge.
`timescale 1ns/1ps

module tb_mem_bus_master;

    localparam int BW = 16;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            resetL = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_rw = 1'b0;
    logic [BW-1:0]   req_addr = '0;
    logic [BL*BW-1:0] req_wdata = '0;
    logic [BL*BW-1:0] rd_data;
    logic            done;
    logic            err;
    logic [BW-1:0]   AddrData_o;
    logic            AddrData_oe;
    logic [BW-1:0]   AddrData_i = '0;
    logic            AddrValid;
    logic            rw;

    mem_bus_master dut (
        .clk(clk), .resetL(resetL), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .rd_data(rd_data),
        .done(done), .err(err), .AddrData_o(AddrData_o), .AddrData_oe(AddrData_oe),
        .AddrData_i(AddrData_i), .AddrValid(AddrValid), .rw(rw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            rw;
        bit            rej;
        logic [15:0]   addr;
        logic [15:0]   wd [BL];
        logic [63:0]   exp_rd;
        int            acc_cyc;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] ref_mem [65536];
    logic [15:0] bus_mem [65536];
    logic [63:0] model_rd = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // memory_top advances the address inside the 4K page and wraps at its top
    function automatic logic [15:0] waddr(input logic [15:0] base, input int k);
        return {base[15:12], 12'(base[11:0] + 12'(k))};
    endfunction

    task automatic send(input bit r, input logic [15:0] a, input logic [63:0] wd);
        txn_t t;
        int   n = 0;
        req_valid = 1'b1;
        req_rw    = r;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("req_ready_timeout");
            req_valid = 1'b0;
            return;
        end
        t.rw      = r;
        t.addr    = a;
        t.acc_cyc = cyc;
`ifdef MBM_PAGE_CHECK_EN
        t.rej = (a[15:12] != 4'h2);
`else
        t.rej = 1'b0;
`endif
        for (int k = 0; k < BL; k++) t.wd[k] = wd[k*16 +: 16];
        if (!t.rej) begin
            for (int k = 0; k < BL; k++) begin
                if (r) model_rd[k*16 +: 16] = ref_mem[waddr(a, k)];
                else   ref_mem[waddr(a, k)] = t.wd[k];
            end
        end
        t.exp_rd = model_rd;
        sb.push_back(t);
        @(posedge clk);
        #1;
        // scramble the request inputs: the accepted burst must not follow them
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(negedge clk);
    endtask

    // monitor: bus-side memory model plus scoreboard checks
    initial begin
        bit          active = 1'b0;
        int          beat = 0;
        int          addr_cyc = 0;
        txn_t        cur;
        txn_t        t;
        logic [15:0] last_drv = '0;
        forever begin
            @(negedge clk);
            if (!resetL) begin
                sb.delete();
                active   = 1'b0;
                last_drv = '0;
                check("rst_addrvalid", AddrValid, 0);
                check("rst_oe", AddrData_oe, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                check("rst_rw", rw, 0);
                check("rst_ready", req_ready, 1);
                check("rst_addrdata", AddrData_o, 0);
                check("rst_rd_data", rd_data, 0);
                continue;
            end
            if (done) begin
                if (sb.size() == 0) fail_now("done_without_txn");
                else begin
                    t = sb.pop_front();
                    check("done_in_burst", active, 0);
                    check("done_on_rejected", t.rej, 0);
                    check("done_latency", cyc, addr_cyc + BL + 1);
                    check("rd_data", rd_data, t.exp_rd);
                end
            end
            if (err) begin
                if (sb.size() == 0) fail_now("err_without_txn");
                else begin
                    t = sb.pop_front();
                    check("err_expected", t.rej, 1);
                    check("err_latency", cyc, t.acc_cyc + 1);
                end
            end
            if (AddrValid) begin
                AddrData_i = 16'($urandom);
                if (sb.size() == 0) fail_now("addr_without_txn");
                else begin
                    cur = sb[0];
                    check("addr_in_burst", active, 0);
                    check("addr_on_rejected", cur.rej, 0);
                    check("addr_value", AddrData_o, cur.addr);
                    check("addr_rw", rw, cur.rw);
                    check("addr_oe", AddrData_oe, 1);
                    check("addr_latency", cyc, cur.acc_cyc + 1);
                    active   = 1'b1;
                    beat     = 0;
                    addr_cyc = cyc;
                end
            end else if (active) begin
                check("data_rw", rw, 0);
                if (!cur.rw) begin
                    check("wr_oe", AddrData_oe, 1);
                    check("wr_word", AddrData_o, cur.wd[beat]);
                    bus_mem[waddr(cur.addr, beat)] = AddrData_o;
                end else begin
                    check("rd_oe", AddrData_oe, 0);
                    AddrData_i = bus_mem[waddr(cur.addr, beat)];
                end
                beat++;
                if (beat == BL) active = 1'b0;
            end else begin
                check("idle_oe", AddrData_oe, 0);
                check("idle_rw", rw, 0);
                check("idle_hold", AddrData_o, last_drv);
                AddrData_i = 16'($urandom);
            end
            last_drv = AddrData_o;
        end
    end

    initial begin
        logic [63:0] wd;
        logic [15:0] a;
        logic [3:0]  pg;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 16'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        resetL = 1'b1;
        #1;
        check("ready_after_reset", req_ready, 1);

        // T1 write then T2 read of the same page-crossing base
        send(1'b0, 16'h2FFE, {16'd4, 16'd3, 16'd2, 16'd1});
        wait_idle();
        send(1'b1, 16'h2FFE, {$urandom, $urandom});
        wait_idle();
        check("t2_rd_data", rd_data, 64'h0004_0003_0002_0001);

        // T3 back-to-back write then read
        send(1'b0, 16'h2A10, {$urandom, $urandom});
        send(1'b1, 16'h2A10, {$urandom, $urandom});
        wait_idle();

        // T4 reset during DATA2 of a write (data equals memory so partial writes are harmless)
        for (int k = 0; k < BL; k++) wd[k*16 +: 16] = ref_mem[waddr(16'h2100, k)];
        send(1'b0, 16'h2100, wd);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetL = 1'b0;
        #1;
        check("t4_oe", AddrData_oe, 0);
        check("t4_addrvalid", AddrValid, 0);
        check("t4_ready", req_ready, 1);
        model_rd = '0;
        repeat (2) @(negedge clk);
        resetL = 1'b1;
        send(1'b1, 16'h2100, {$urandom, $urandom});
        wait_idle();

        // T5 off-page request, then read back the page that must be untouched
        send(1'b0, 16'h0F00, {$urandom, $urandom});
        send(1'b1, 16'h2F00, {$urandom, $urandom});
        wait_idle();

        // randomized traffic with mixed gaps, pages and directions
        for (int i = 0; i < 60; i++) begin
            pg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h2;
            a  = {pg, 12'($urandom)};
            if ($urandom_range(0, 4) == 0) a[11:0] = 12'hFFE;
            if ($urandom_range(0, 2) == 0) a[11:0] = {8'h01, 4'($urandom_range(0, 3))};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(1'($urandom), a, {$urandom, $urandom});
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
